// File: rtl/bus_pkg.sv
// Shared definitions for the datapath bus responder.
//   DEF_WIDTH / DEF_AWIDTH : default data and address widths
//   BUS_RD / BUS_WR        : encoding of the RW strobe
//   bus_state_e            : responder FSM state encoding
package bus_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_AWIDTH = 8;

  localparam logic BUS_RD = 1'b0;
  localparam logic BUS_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_mem_responder_if.sv
// Control side of the shared datapath bus.
//   Address : word address, master -> responder
//   Valid   : request strobe, held by the master until Ready is seen
//   RW      : 1 = write, 0 = read
//   Ready   : access complete, responder -> master
//   Err     : captured address was outside the store, valid with Ready
// The tri-state data lines are a plain inout on the responder so the
// resolved net lives with whoever instantiates the bus.
interface bus_mem_responder_if
  import bus_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH
);

  logic [AWIDTH-1:0] Address;
  logic              Valid;
  logic              RW;
  logic              Ready;
  logic              Err;

  modport master (output Address, Valid, RW, input Ready, Err);
  modport slave  (input Address, Valid, RW, output Ready, Err);

endinterface

// File: rtl/bus_mem_responder_mem_array.sv
// Word store behind the bus responder.
//   clk   : write clock
//   we    : write enable, array updated on the rising edge
//   waddr : write index
//   wdata : write data
//   raddr : read index, combinational read
//   rdata : read data
// No reset: contents survive a bus reset.
module mem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int IW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the datapath Address/data bus.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : Address/Valid/RW in, Ready/Err out (slave modport)
//   data  : tri-state data bus, driven only while acknowledging a read
// Requests are accepted only in IDLE. Writes commit at the accepting edge;
// reads are answered after RD_LAT cycles. Every access ends with a
// four-phase Valid/Ready handshake.
// DEPTH must be <= 2**AWIDTH and RD_LAT >= 1; the interface AWIDTH must
// match this module's AWIDTH.
//
// state | meaning
// IDLE  | no access in progress, sampling Valid
// WAIT  | read accepted, counting down the read latency
// ACK   | Ready (and Err) asserted, read data on the bus, waiting for Valid low
module bus_mem_responder
  import bus_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  bus_mem_responder_if.slave bus,
  inout  wire [WIDTH-1:0]    data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Counter only ever holds RD_LAT-1 down to 1.
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [AWIDTH:0] DEPTH_W  = (AWIDTH + 1)'(DEPTH);
  localparam logic [CW-1:0]   CNT_INIT = CW'(RD_LAT - 1);

  bus_state_e       state_q,   state_d;
  logic [IW-1:0]    idx_q,     idx_d;
  logic             addr_ok_q, addr_ok_d;
  logic             rw_q,      rw_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [WIDTH-1:0] rdata_q,   rdata_d;
  logic             ready_q,   ready_d;
  logic             err_q,     err_d;
  logic             drive_q,   drive_d;

  logic             req_ok;
  logic [IW-1:0]    req_idx;
  logic             mem_we;
  logic [IW-1:0]    mem_raddr;
  logic [WIDTH-1:0] mem_rdata;

  // Addresses are never wrapped: anything at or above DEPTH is an error.
  assign req_ok  = ({1'b0, bus.Address} < DEPTH_W);
  assign req_idx = bus.Address[IW-1:0];

  // Write data is taken straight off the bus at the accepting edge, so no
  // separate write-data capture register is needed.
  assign mem_we    = !reset && (state_q == IDLE) && bus.Valid &&
                     (bus.RW == BUS_WR) && req_ok;
  assign mem_raddr = (state_q == IDLE) ? req_idx : idx_q;

  mem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (req_idx),
    .wdata (data),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_ok_d = addr_ok_q;
    rw_d      = rw_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    ready_d   = ready_q;
    err_d     = err_q;
    drive_d   = drive_q;

    unique case (state_q)
      IDLE: begin
        if (bus.Valid) begin
          idx_d     = req_idx;
          addr_ok_d = req_ok;
          rw_d      = bus.RW;
          if (bus.RW == BUS_WR) begin
            state_d = ACK;
            ready_d = 1'b1;
            err_d   = !req_ok;
          end else if (RD_LAT == 1) begin
            rdata_d = req_ok ? mem_rdata : '0;
            state_d = ACK;
            ready_d = 1'b1;
            err_d   = !req_ok;
            drive_d = 1'b1;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        // Abort has priority over completion: the master gave up.
        if (!bus.Valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(1)) begin
          rdata_d = addr_ok_q ? mem_rdata : '0;
          cnt_d   = '0;
          state_d = ACK;
          ready_d = 1'b1;
          err_d   = !addr_ok_q;
          drive_d = (rw_q == BUS_RD);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ACK: begin
        if (!bus.Valid) begin
          state_d = IDLE;
          ready_d = 1'b0;
          err_d   = 1'b0;
          drive_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ready_d = 1'b0;
        err_d   = 1'b0;
        drive_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      addr_ok_q <= 1'b0;
      rw_q      <= BUS_RD;
      cnt_q     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      drive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_ok_q <= addr_ok_d;
      rw_q      <= rw_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      drive_q   <= drive_d;
    end
  end

  assign bus.Ready = ready_q;
  assign bus.Err   = err_q;
  assign data      = drive_q ? rdata_q : {WIDTH{1'bz}};

endmodule
